// File: rtl/raw2rgb_bayer_param_if.sv
// Pixel-stream bundle for the Bayer demosaic stage: raw input side driven by the
// capture FIFO reader, RGB output side consumed by the VGA/Sobel pipeline.
interface raw2rgb_bayer_param_if #(
  parameter int DW = 10,
  parameter int OW = 8,
  parameter int XW = 11,
  parameter int YW = 11
);
  logic          VGA_VS;
  logic [1:0]    iPATTERN;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic [OW-1:0] oRed;
  logic [OW-1:0] oGreen;
  logic [OW-1:0] oBlue;
  logic          oDVAL;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic          oOVF;

  modport master (
    output VGA_VS, iPATTERN, iDATA, iDVAL,
    input  oRed, oGreen, oBlue, oDVAL, oX, oY, oOVF
  );

  modport slave (
    input  VGA_VS, iPATTERN, iDATA, iDVAL,
    output oRed, oGreen, oBlue, oDVAL, oX, oY, oOVF
  );
endinterface

// File: rtl/raw2rgb_bayer_param.sv
// 2x2-window Bayer demosaic with one-line RAM: one RGB pixel out per raw pixel in,
// two cycles of latency, per-frame Bayer phase and sticky line-overflow flag.
module raw2rgb_bayer_param #(
  parameter int DW       = 10,
  parameter int OW       = 8,
  parameter int LINE_MAX = 1024,
  parameter int XW       = 11,
  parameter int YW       = 11
) (
  input  logic                  VGA_CLK,
  input  logic                  RST_N,
  raw2rgb_bayer_param_if.slave  bus
);

  localparam int            AW         = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [XW-1:0] LINE_MAX_X = XW'(LINE_MAX);
  localparam logic [XW-1:0] X_MAX      = '1;
  localparam logic [YW-1:0] Y_MAX      = '1;

  // Top OW bits when narrowing, zero-filled left shift when widening.
  function automatic logic [OW-1:0] to_ow(input logic [DW-1:0] v);
    logic [DW+OW-1:0] w;
    w = {v, {OW{1'b0}}};
    return w[DW+OW-1 -: OW];
  endfunction

  logic          vs;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd;
  logic          ram_we;

  // Input-side counters and per-frame state
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          dval_q, dval_d;
  logic [1:0]    pat_q, pat_d;
  logic          ovf_q, ovf_d;

  // S1 window stage
  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] p_q, p_d, q_q, q_d, pp_q, pp_d, qp_q, qp_d;
  logic [XW-1:0] s1x_q, s1x_d;
  logic [YW-1:0] s1y_q, s1y_d;

  // Output stage
  logic          out_vld_q, out_vld_d;
  logic [OW-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;

  logic [DW-1:0] mem [LINE_MAX];

  assign vs       = bus.VGA_VS;
  assign ram_addr = x_q[AW-1:0];
  assign ram_rd   = mem[ram_addr];
  assign ram_we   = vs && bus.iDVAL && (x_q < LINE_MAX_X);

  // NOTE: the line RAM has no reset; stale rows are masked by y==0 blanking.
  always_ff @(posedge VGA_CLK) begin
    if (ram_we) mem[ram_addr] <= bus.iDATA;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    x_d      = x_q;
    y_d      = y_q;
    dval_d   = dval_q;
    pat_d    = pat_q;
    ovf_d    = ovf_q;
    s1_vld_d = 1'b0;
    p_d      = p_q;
    q_d      = q_q;
    pp_d     = pp_q;
    qp_d     = qp_q;
    s1x_d    = s1x_q;
    s1y_d    = s1y_q;
    if (!vs) begin
      x_d    = '0;
      y_d    = '0;
      dval_d = 1'b0;
      pat_d  = bus.iPATTERN;
      ovf_d  = 1'b0;
    end else begin
      dval_d = bus.iDVAL;
      if (bus.iDVAL) begin
        x_d      = (x_q == X_MAX) ? x_q : x_q + 1'b1;
        if (x_q == LINE_MAX_X) ovf_d = 1'b1;
        s1_vld_d = 1'b1;
        p_d      = bus.iDATA;
        q_d      = ram_rd;
        pp_d     = p_q;
        qp_d     = q_q;
        s1x_d    = x_q;
        s1y_d    = y_q;
      end else if (dval_q) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? y_q : y_q + 1'b1;
      end
    end
  end

  logic          r_bottom, r_right, blank;
  logic [DW-1:0] r_raw, b_raw, g1, g2, g_raw;
  logic [DW:0]   g_sum;

  always_comb begin
    r_bottom = (s1y_q[0] == pat_q[1]);
    r_right  = (s1x_q[0] == pat_q[0]);
    // Window cells: TL=qp, TR=q, BL=pp, BR=p; blue is diagonal to red.
    unique case ({r_bottom, r_right})
      2'b00:   begin r_raw = qp_q; b_raw = p_q;  g1 = q_q;  g2 = pp_q; end
      2'b01:   begin r_raw = q_q;  b_raw = pp_q; g1 = qp_q; g2 = p_q;  end
      2'b10:   begin r_raw = pp_q; b_raw = q_q;  g1 = qp_q; g2 = p_q;  end
      default: begin r_raw = p_q;  b_raw = qp_q; g1 = q_q;  g2 = pp_q; end
    endcase
    g_sum = {1'b0, g1} + {1'b0, g2};
    g_raw = DW'(g_sum >> 1);
    blank = (s1y_q == '0) || (s1x_q == '0) || (s1x_q >= LINE_MAX_X);

    out_vld_d = s1_vld_q && vs;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    if (out_vld_d) begin
      ox_d    = s1x_q;
      oy_d    = s1y_q;
      red_d   = blank ? '0 : to_ow(r_raw);
      green_d = blank ? '0 : to_ow(g_raw);
      blue_d  = blank ? '0 : to_ow(b_raw);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q       <= '0;
      y_q       <= '0;
      dval_q    <= 1'b0;
      pat_q     <= 2'd0;
      ovf_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      p_q       <= '0;
      q_q       <= '0;
      pp_q      <= '0;
      qp_q      <= '0;
      s1x_q     <= '0;
      s1y_q     <= '0;
      out_vld_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dval_q    <= dval_d;
      pat_q     <= pat_d;
      ovf_q     <= ovf_d;
      s1_vld_q  <= s1_vld_d;
      p_q       <= p_d;
      q_q       <= q_d;
      pp_q      <= pp_d;
      qp_q      <= qp_d;
      s1x_q     <= s1x_d;
      s1y_q     <= s1y_d;
      out_vld_q <= out_vld_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
    end
  end

  assign bus.oRed   = red_q;
  assign bus.oGreen = green_q;
  assign bus.oBlue  = blue_q;
  assign bus.oDVAL  = out_vld_q;
  assign bus.oX     = ox_q;
  assign bus.oY     = oy_q;
  assign bus.oOVF   = ovf_q;

endmodule

// File: tb/tb_raw2rgb_bayer_param.sv
// Two demosaic instances (10->8 bit and 8->10 bit, 8-pixel lines) driven in lockstep
// and compared every cycle against a window-level Bayer model.
module tb_raw2rgb_bayer_param;

  localparam int LM   = 8;
  localparam int XW   = 4;
  localparam int YW   = 3;
  localparam int XSAT = (1 << XW) - 1;
  localparam int YSAT = (1 << YW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raw2rgb_bayer_param_if #(.DW(10), .OW(8),  .XW(XW), .YW(YW)) bus_a ();
  raw2rgb_bayer_param_if #(.DW(8),  .OW(10), .XW(XW), .YW(YW)) bus_b ();

  raw2rgb_bayer_param #(.DW(10), .OW(8), .LINE_MAX(LM), .XW(XW), .YW(YW)) dut_a (
    .VGA_CLK (clk),
    .RST_N   (rst_n),
    .bus     (bus_a)
  );

  raw2rgb_bayer_param #(.DW(8), .OW(10), .LINE_MAX(LM), .XW(XW), .YW(YW)) dut_b (
    .VGA_CLK (clk),
    .RST_N   (rst_n),
    .bus     (bus_b)
  );

  typedef struct {
    bit vld;
    int r, g, b, x, y;
  } exp_t;

  // Colour of each 2x2 tile position (row%2*2 + col%2): 0=R, 1=G, 2=B.
  int lut [4][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};
  int dws [2] = '{10, 8};
  int ows [2] = '{8, 10};

  int   m_x, m_y, m_pat, ipat;
  bit   m_dprev, m_ovf;
  int   ram [2][LM];
  int   top [2][LM];
  int   cur [2][LM];
  exp_t pend [2];
  exp_t held [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scale(int v, int dw, int ow);
    if (dw >= ow) return v >> (dw - ow);
    return v << (ow - dw);
  endfunction

  function automatic int flat_pix(int d, int row, int col);
    case (lut[0][(row % 2) * 2 + col % 2])
      0:       return (d == 0) ? 'h3FC : 'hAB;
      1:       return (d == 0) ? 'h200 : 'h80;
      default: return (d == 0) ? 'h004 : 'h10;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_pat = 0; m_dprev = 0; m_ovf = 0;
    for (int d = 0; d < 2; d++) begin
      pend[d] = '{vld: 0, r: 0, g: 0, b: 0, x: 0, y: 0};
      held[d] = '{vld: 0, r: 0, g: 0, b: 0, x: 0, y: 0};
    end
  endtask

  // Expected output for the pixel at (m_y, m_x): average greens, pick R and B by
  // the absolute Bayer colour of each window cell.
  task automatic model_pixel(int d, int data, output exp_t e);
    int rs, bs, gs, row, col, v;
    e.vld = 1; e.x = m_x; e.y = m_y;
    if (m_x < LM) begin
      top[d][m_x] = ram[d][m_x];
      cur[d][m_x] = data;
      ram[d][m_x] = data;
    end
    if (m_y == 0 || m_x == 0 || m_x >= LM) begin
      e.r = 0; e.g = 0; e.b = 0;
    end else begin
      rs = 0; bs = 0; gs = 0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          row = m_y - 1 + dr;
          col = m_x - 1 + dc;
          v   = (dr == 1) ? cur[d][col] : top[d][col];
          case (lut[m_pat][(row % 2) * 2 + col % 2])
            0:       rs = v;
            2:       bs = v;
            default: gs = gs + v;
          endcase
        end
      end
      e.r = scale(rs, dws[d], ows[d]);
      e.g = scale(gs / 2, dws[d], ows[d]);
      e.b = scale(bs, dws[d], ows[d]);
    end
  endtask

  task automatic step(bit vs, bit dv, int da, int db);
    exp_t old [2];
    bus_a.VGA_VS = vs;   bus_b.VGA_VS = vs;
    bus_a.iDVAL  = dv;   bus_b.iDVAL  = dv;
    bus_a.iPATTERN = 2'(ipat); bus_b.iPATTERN = 2'(ipat);
    bus_a.iDATA  = 10'(da);
    bus_b.iDATA  = 8'(db);
    @(posedge clk);
    #1;
    old = pend;
    if (!vs) begin
      m_x = 0; m_y = 0; m_ovf = 0; m_pat = ipat; m_dprev = 0;
      pend[0].vld = 0; pend[1].vld = 0;
    end else if (dv) begin
      model_pixel(0, da, pend[0]);
      model_pixel(1, db, pend[1]);
      if (m_x == LM) m_ovf = 1;
      if (m_x < XSAT) m_x++;
      m_dprev = 1;
    end else begin
      if (m_dprev) begin
        m_x = 0;
        if (m_y < YSAT) m_y++;
      end
      m_dprev = 0;
      pend[0].vld = 0; pend[1].vld = 0;
    end
    for (int d = 0; d < 2; d++) if (old[d].vld && vs) held[d] = old[d];
    chk("a_dval",  32'(bus_a.oDVAL),  32'(old[0].vld && vs));
    chk("a_red",   32'(bus_a.oRed),   32'(held[0].r));
    chk("a_green", 32'(bus_a.oGreen), 32'(held[0].g));
    chk("a_blue",  32'(bus_a.oBlue),  32'(held[0].b));
    chk("a_x",     32'(bus_a.oX),     32'(held[0].x));
    chk("a_y",     32'(bus_a.oY),     32'(held[0].y));
    chk("a_ovf",   32'(bus_a.oOVF),   32'(m_ovf));
    chk("b_dval",  32'(bus_b.oDVAL),  32'(old[1].vld && vs));
    chk("b_red",   32'(bus_b.oRed),   32'(held[1].r));
    chk("b_green", 32'(bus_b.oGreen), 32'(held[1].g));
    chk("b_blue",  32'(bus_b.oBlue),  32'(held[1].b));
    chk("b_x",     32'(bus_b.oX),     32'(held[1].x));
    chk("b_y",     32'(bus_b.oY),     32'(held[1].y));
    chk("b_ovf",   32'(bus_b.oOVF),   32'(m_ovf));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic frame(int pat);
    ipat = pat;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  // One line of n pixels followed by the single idle cycle that closes it.
  task automatic drive_line(int n, bit flat);
    for (int i = 0; i < n; i++) begin
      if (flat) step(1, 1, flat_pix(0, m_y, i), flat_pix(1, m_y, i));
      else      step(1, 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
    end
    step(1, 0, 0, 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_a_out"}, {bus_a.oRed, bus_a.oGreen, bus_a.oBlue, bus_a.oDVAL,
                          bus_a.oX, bus_a.oY, bus_a.oOVF}, 32'd0);
    chk({tag, "_b_out"}, {bus_b.oRed[9:0], bus_b.oBlue[9:0], bus_b.oDVAL,
                          bus_b.oX, bus_b.oY, bus_b.oOVF}, 32'd0);
    chk({tag, "_b_grn"}, 32'(bus_b.oGreen), 32'd0);
  endtask

  initial begin
    ipat = 0;
    bus_a.VGA_VS = 1'b1; bus_b.VGA_VS = 1'b1;
    bus_a.iDVAL  = 1'b0; bus_b.iDVAL  = 1'b0;
    bus_a.iPATTERN = 2'd0; bus_b.iPATTERN = 2'd0;
    bus_a.iDATA  = '0;   bus_b.iDATA  = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < LM; i++) begin ram[d][i] = 0; top[d][i] = 0; cur[d][i] = 0; end
    model_reset();

    // Reset state
    #3;
    chk_all_zero("reset");
    #9 rst_n = 1'b1;
    idle(2);

    // Warm-up frame fills every RAM column
    frame(0);
    drive_line(8, 0);
    drive_line(8, 0);
    idle(3);

    // RGGB flat field 4x4; last output is (3,3)
    frame(0);
    for (int l = 0; l < 4; l++) drive_line(4, 1);
    idle(3);
    chk("flat_red",   32'(bus_a.oRed),   32'h0FF);
    chk("flat_green", 32'(bus_a.oGreen), 32'h080);
    chk("flat_blue",  32'(bus_a.oBlue),  32'h001);
    chk("wide_red",   32'(bus_b.oRed),   32'h2AC);

    // Same raw frame read as BGGR; a mid-frame iPATTERN change must not apply
    frame(3);
    drive_line(4, 1);
    drive_line(4, 1);
    ipat = 0;
    drive_line(4, 1);
    drive_line(4, 1);
    idle(3);
    chk("swap_red",  32'(bus_a.oRed),  32'h001);
    chk("swap_blue", 32'(bus_a.oBlue), 32'h0FF);

    // Green averaging: G1=0x3FF, G2=0x001, then odd sum 0x201+0x200
    frame(0);
    step(1, 1, 'h3FC, 'hAB); step(1, 1, 'h3FF, 'h80); step(1, 0, 0, 0);
    step(1, 1, 'h001, 'h80); step(1, 1, 'h004, 'h10); step(1, 0, 0, 0);
    idle(3);
    chk("gavg_green", 32'(bus_a.oGreen), 32'h080);
    frame(0);
    step(1, 1, 'h3FC, 'hAB); step(1, 1, 'h201, 'h81); step(1, 0, 0, 0);
    step(1, 1, 'h200, 'h80); step(1, 1, 'h004, 'h10); step(1, 0, 0, 0);
    idle(3);
    chk("godd_green", 32'(bus_a.oGreen), 32'h080);
    chk("godd_wide_green", 32'(bus_b.oGreen), 32'h200);

    // Overflow: 10-pixel line, RAM reuse on the next line, then x saturation
    frame(int'($urandom_range(0, 3)));
    drive_line(10, 0);
    chk("ovf_set", 32'(bus_a.oOVF), 32'd1);
    drive_line(8, 0);
    drive_line(18, 0);
    idle(3);
    chk("x_sat", 32'(bus_a.oX), 32'(XSAT));
    frame(0);
    chk("ovf_clr", 32'(bus_a.oOVF), 32'd0);

    // y saturation
    for (int l = 0; l < 10; l++) drive_line(3, 0);
    idle(3);
    chk("y_sat", 32'(bus_b.oY), 32'(YSAT));

    // Random frames, including an aborted line with iDVAL held during VS low
    for (int f = 0; f < 3; f++) begin
      int nl;
      frame(int'($urandom_range(0, 3)));
      nl = int'($urandom_range(2, 6));
      for (int l = 0; l < nl; l++) drive_line(int'($urandom_range(1, LM + 2)), 0);
      for (int i = 0; i < 3; i++)
        step(1, 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
      step(0, 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
    end
    frame(2);
    drive_line(8, 0);
    drive_line(8, 0);
    idle(3);

    // Asynchronous reset mid-line; pattern returns to RGGB without a VS pulse
    frame(3);
    drive_line(8, 1);
    step(1, 1, flat_pix(0, 1, 0), flat_pix(1, 1, 0));
    step(1, 1, flat_pix(0, 1, 1), flat_pix(1, 1, 1));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus_a.iDVAL = 1'b0; bus_b.iDVAL = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_line(8, 1);
    drive_line(8, 1);
    idle(3);
    chk("rst_pat_red", 32'(bus_a.oRed), 32'h0FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/raw2rgb_bayer_param.md
Name: raw2rgb_bayer_param

Overview:
- Parametrised successor to the fixed 10-bit 2x2-bin demosaic stage between the D8M capture FIFO read side and the VGA/Sobel pipeline.
- Accepts one raw Bayer pixel per valid cycle and keeps one previous line in internal RAM.
- Forms a 2x2 window and emits one RGB pixel per input pixel.
- Generalised over pixel width, output width, line length and Bayer phase, which is runtime-selectable per frame. Adds output valid, coordinates and overflow reporting.

Parameters:
- DW, 10, raw pixel width (>=2).
- OW, 8, output width per colour channel (1..16).
- LINE_MAX, 1024, maximum pixels per line; line RAM depth.
- XW, 11, width of X counter and oX (2^XW > LINE_MAX).
- YW, 11, width of Y counter and oY.

Ports:
- VGA_CLK  in  1  sole clock, all logic rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- VGA_VS  in  1  frame sync, active low; level-sensitive, sampled synchronously.
- iPATTERN  in  2  Bayer phase: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR; latched while VGA_VS=0.
- iDATA  in  DW  raw pixel.
- iDVAL  in  1  pixel valid (read request); high for the whole active line.
- oRed  out  OW  red channel.
- oGreen  out  OW  green channel.
- oBlue  out  OW  blue channel.
- oDVAL  out  1  output pixel valid.
- oX  out  XW  column of the output pixel.
- oY  out  YW  row of the output pixel.
- oOVF  out  1  sticky flag: line exceeded LINE_MAX in the current frame.

Behaviour:
- Reset (RST_N=0, async): all counters, pipeline registers and outputs = 0; pattern register = 0 (RGGB). Line RAM contents are undefined and are not cleared.
- Frame start (VGA_VS=0, sync): x=y=0, oOVF=0, pattern register <= iPATTERN, oDVAL=0. iDVAL is ignored while VGA_VS=0.
- Counters:
  - x increments on every iDVAL=1 cycle and saturates at 2^XW-1.
  - An iDVAL falling edge (registered iDVAL=1, iDVAL=0) clears x and increments y, saturating at 2^YW-1.
- Line RAM:
  - Single-clock, read-before-write at address x, active only when iDVAL=1 and x<LINE_MAX.
  - Read yields q(x), the previous line's pixel; iDATA is written as p(x).
- Window stage (S1): registers p(x), q(x) and the previous pair p(x-1), q(x-1).
- Window cells: TL=q(x-1), TR=q(x), BL=p(x-1), BR=p(x); BR sits at absolute (y,x).
- Colour selection in the window, with pat = pattern register:
  - R row = bottom if y[0]==pat[1], else top.
  - R col = right if x[0]==pat[0], else left.
  - B = cell diagonally opposite R; the remaining two cells are G1 and G2.
- Arithmetic:
  - G = (G1+G2)>>1, computed in DW+1 bits then truncated to DW.
  - Width conversion: if DW>=OW take the top OW bits; else left-shift with zero fill.
- Blanking: output 0,0,0 when y==0, x==0, or x>=LINE_MAX. oDVAL still follows iDVAL in all these cases.
- Latency: oDVAL, colours, oX and oY appear exactly 2 cycles after the iDVAL=1 input cycle. oX/oY are the x/y of that input pixel.
- Overflow: the first pixel with x==LINE_MAX sets oOVF. oOVF holds until the next VGA_VS=0. RAM is not written for that pixel or any later pixel in the line.
- Back-to-back lines with a single idle cycle between them are supported. A 1-cycle iDVAL low completes the line.
- Mid-line VGA_VS=0 aborts the line:
  - counters clear and the pipeline drains (oDVAL=0 from the next cycle);
  - RAM contents are retained but treated as stale: y=0 blanking covers this.
- iPATTERN changes while VGA_VS=1 have no effect until the next frame.
- Output registers hold their last value while oDVAL=0.

Test Plan:
- Reset: assert RST_N=0 mid-line -> all outputs 0 on the next edge with no clock dependency; pattern reverts to RGGB.
- RGGB flat field, 4x4, DW=10, OW=8:
  - Stimulus: R=0x3FC, G=0x200, B=0x004.
  - Row 0 and column 0 output 0 with oDVAL=1.
  - Every other pixel outputs oRed=0xFF, oGreen=0x80, oBlue=0x01.
  - oDVAL lags iDVAL by exactly 2 cycles.
- Pattern switch: same raw frame with iPATTERN=3 latched -> red and blue swapped (oRed=0x01, oBlue=0xFF). A change on iPATTERN while VS=1 -> no effect until the next VS low.
- Green averaging: G1=0x3FF, G2=0x001 -> oGreen=0x80. Odd sum 0x201+0x200 truncates -> oGreen=0x80.
- Overflow, LINE_MAX=8, 10-pixel line:
  - pixels 8 and 9 output zeros with oDVAL=1;
  - oOVF=1 from the cycle after pixel 8 is accepted, until VGA_VS low;
  - RAM entries 0..7 are intact on the next line.
- Width parameters: DW=8, OW=10, input 0xAB in the R position -> oRed=0x2AC; y saturation at 2^YW-1 is also checked.
